// File: rtl/mips_run_ctrl.sv
// Run sequencer for the MIPS core: holds the core in reset, counts run cycles and stops on halt, idle PC or timeout.
// Optional idle-PC detection is compiled in with `define MIPS_RUN_CTRL_IDLE_DETECT_EN.
module mips_run_ctrl #(
   parameter int RST_CYCLES  = 5,
   parameter int MAX_CYCLES  = 10000,
   parameter int IDLE_CYCLES = 4,
   parameter int PC_W        = 32,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt_req,
   input  logic [PC_W-1:0]  pc,
   output logic             core_reset,
   output logic             running,
   output logic             done,
   output logic [1:0]       stop_code,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int RST_W = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {
      S_RST,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   logic [RST_W-1:0] rst_cnt;
   logic             idle;
   logic             timeout;

   assign timeout = (cycle_count == CNT_W'(MAX_CYCLES - 1));

`ifdef MIPS_RUN_CTRL_IDLE_DETECT_EN
   localparam int STALL_W = $clog2(IDLE_CYCLES) + 1;

   logic [PC_W-1:0]    pc_q;
   logic [STALL_W-1:0] stall;
   logic               same;

   assign same = (pc == pc_q);
   assign idle = same && (stall == STALL_W'(IDLE_CYCLES - 2));

   // The stall counter only matters in RUN, so it is held at zero elsewhere.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= '0;
         stall <= '0;
      end else begin
         pc_q <= pc;
         if (state == S_RUN) begin
            if (same)
               stall <= stall + STALL_W'(1);
            else
               stall <= '0;
         end else begin
            stall <= '0;
         end
      end
   end
`else
   logic unused_pc;

   assign idle      = 1'b0;
   assign unused_pc = ^pc;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_RST;
         core_reset  <= 1'b1;
         running     <= 1'b0;
         done        <= 1'b0;
         stop_code   <= 2'd0;
         cycle_count <= '0;
         rst_cnt     <= '0;
      end else begin
         unique case (state)
            S_RST: begin
               rst_cnt <= rst_cnt + RST_W'(1);
               if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                  state      <= S_RUN;
                  core_reset <= 1'b0;
                  running    <= 1'b1;
               end
            end
            S_RUN: begin
               // The terminating edge is counted as well.
               cycle_count <= cycle_count + CNT_W'(1);
               if (halt_req || idle || timeout) begin
                  state   <= S_DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
                  if (halt_req)
                     stop_code <= 2'd1;
                  else if (idle)
                     stop_code <= 2'd2;
                  else
                     stop_code <= 2'd3;
               end
            end
            S_DONE: begin
               if (start) begin
                  state       <= S_RST;
                  core_reset  <= 1'b1;
                  done        <= 1'b0;
                  stop_code   <= 2'd0;
                  cycle_count <= '0;
                  rst_cnt     <= '0;
               end
            end
            default: begin
               state      <= S_RST;
               core_reset <= 1'b1;
               running    <= 1'b0;
               done       <= 1'b0;
               rst_cnt    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl with default parameters.
module tb_mips_run_ctrl;

   typedef struct packed {
      logic [1:0]  code;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        halt_req;
   logic [31:0] pc;
   logic        core_reset;
   logic        running;
   logic        done;
   logic [1:0]  stop_code;
   logic [31:0] cycle_count;

   logic        pc_inc;
   logic [31:0] pc_stop;
   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;

   mips_run_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .halt_req    (halt_req),
      .pc          (pc),
      .core_reset  (core_reset),
      .running     (running),
      .done        (done),
      .stop_code   (stop_code),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      if (pc_inc && pc != pc_stop)
         pc = pc + 32'd4;
   endtask

   // Core reset must hold for exactly 5 edges, then RUN starts with count 0.
   task automatic rst_seq(input string tag);
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++;
         if ({core_reset, running} !== 2'b10) begin
            errors++;
            $display("FAIL %s rst edge %0d: core_reset/running=%b required 10",
                     tag, i, {core_reset, running});
         end
      end
      step();
      checks++;
      if ({core_reset, running, done, cycle_count} !== {3'b010, 32'd0}) begin
         errors++;
         $display("FAIL %s run entry: cr/run/done=%b count=%0d required 010 count=0",
                  tag, {core_reset, running, done}, cycle_count);
      end
   endtask

   task automatic finish_run(input string tag);
      int   n;
      exp_t e;
      n = 0;
      while (done !== 1'b1 && n < 20000) begin
         step();
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done timeout: done=%b required 1", tag, done);
      end
      e = exp_q.pop_front();
      checks++;
      if (stop_code !== e.code) begin
         errors++;
         $display("FAIL %s stop_code: got %0d required %0d", tag, stop_code, e.code);
      end
      checks++;
      if (cycle_count !== e.cnt) begin
         errors++;
         $display("FAIL %s cycle_count: got %0d required %0d", tag, cycle_count, e.cnt);
      end
      checks++;
      if ({running, core_reset} !== 2'b00) begin
         errors++;
         $display("FAIL %s done outputs: running/core_reset=%b required 00",
                  tag, {running, core_reset});
      end
      step();
      checks++;
      if ({done, stop_code, cycle_count} !== {1'b1, e.code, e.cnt}) begin
         errors++;
         $display("FAIL %s frozen: done=%b code=%0d count=%0d required 1 %0d %0d",
                  tag, done, stop_code, cycle_count, e.code, e.cnt);
      end
   endtask

   task automatic restart(input string tag);
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if ({core_reset, running, done, stop_code, cycle_count} !== {3'b100, 2'd0, 32'd0}) begin
         errors++;
         $display("FAIL %s start: cr/run/done=%b code=%0d count=%0d required 100 0 0",
                  tag, {core_reset, running, done}, stop_code, cycle_count);
      end
      rst_seq(tag);
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      start    = 1'b0;
      halt_req = 1'b0;
      pc       = 32'd0;
      pc_inc   = 1'b1;
      pc_stop  = 32'hFFFF_FFFF;
      repeat (3) step();
      checks++;
      if ({core_reset, running, done, stop_code} !== 5'b10000) begin
         errors++;
         $display("FAIL reset outputs: %b required 10000",
                  {core_reset, running, done, stop_code});
      end
      checks++;
      if (cycle_count !== 32'd0) begin
         errors++;
         $display("FAIL reset count: got %0d required 0", cycle_count);
      end
      reset = 1'b0;
      rst_seq("reset");
   endtask

   task automatic test_timeout();
      exp_q.push_back('{code: 2'd3, cnt: 32'd10000});
      finish_run("timeout");
   endtask

   task automatic test_halt();
      int n;
      exp_q.push_back('{code: 2'd1, cnt: 32'd37});
      n = 0;
      while (cycle_count !== 32'd36 && n < 100) begin
         step();
         n++;
      end
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      finish_run("halt37");
   endtask

   task automatic test_halt_on_timeout();
      int n;
      exp_q.push_back('{code: 2'd1, cnt: 32'd10000});
      n = 0;
      while (cycle_count !== 32'd9999 && n < 10100) begin
         step();
         n++;
      end
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      finish_run("halt_on_timeout");
   endtask

   task automatic test_idle();
      pc      = 32'h0000_3000;
      pc_stop = 32'h0000_3010;
`ifdef MIPS_RUN_CTRL_IDLE_DETECT_EN
      exp_q.push_back('{code: 2'd2, cnt: 32'd8});
`else
      exp_q.push_back('{code: 2'd3, cnt: 32'd10000});
`endif
      finish_run("idle");
      pc_stop = 32'hFFFF_FFFF;
   endtask

   task automatic test_start_in_run();
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if ({core_reset, running, done, cycle_count} !== {3'b010, 32'd4}) begin
         errors++;
         $display("FAIL start_in_run: cr/run/done=%b count=%0d required 010 count=4",
                  {core_reset, running, done}, cycle_count);
      end
   endtask

   task automatic test_reset_in_run();
      int n;
      n = 0;
      while (cycle_count !== 32'd200 && n < 300) begin
         step();
         n++;
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({core_reset, running, done, stop_code, cycle_count} !== {3'b100, 2'd0, 32'd0}) begin
         errors++;
         $display("FAIL reset_in_run: cr/run/done=%b code=%0d count=%0d required 100 0 0",
                  {core_reset, running, done}, stop_code, cycle_count);
      end
      rst_seq("reset_in_run");
   endtask

   initial begin
      test_reset();
      test_timeout();
      restart("restart1");
      test_halt();
      restart("restart2");
      test_halt_on_timeout();
      restart("restart3");
      test_idle();
      restart("restart4");
      test_start_in_run();
      test_reset_in_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
